// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives trial codes to an R-2R DAC,
// resolves one bit per step MSB first from a synchronised comparator.
module sar_adc_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp,
    output logic [WIDTH-1:0] dac_out,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW = $clog2(SETTLE + 2);

    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE + 1);
    localparam logic [IW-1:0]    I_MSB    = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             cmp_q1, cmp_s;
    logic [WIDTH-1:0] result, result_nxt;
    logic [IW-1:0]    i, i_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] dac_nxt, data_nxt;
    logic             valid_nxt, busy_nxt;
    logic [WIDTH-1:0] res_upd;
    logic             load;

    // Two-flop synchroniser for the asynchronous comparator output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_q1 <= 1'b0;
            cmp_s  <= 1'b0;
        end else begin
            cmp_q1 <= cmp;
            cmp_s  <= cmp_q1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            result  <= '0;
            i       <= '0;
            cnt     <= '0;
            dac_out <= '0;
            data    <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            result  <= result_nxt;
            i       <= i_nxt;
            cnt     <= cnt_nxt;
            dac_out <= dac_nxt;
            data    <= data_nxt;
            valid   <= valid_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state and datapath; 'load' applies the conversion-start actions
    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        i_nxt      = i;
        cnt_nxt    = cnt;
        dac_nxt    = dac_out;
        data_nxt   = data;
        valid_nxt  = 1'b0;
        busy_nxt   = busy;
        load       = 1'b0;
        res_upd    = result;
        res_upd[i] = cmp_s;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    load = 1'b1;
                end
            end
            CONV: begin
                if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    result_nxt = res_upd;
                    if (i != '0) begin
                        i_nxt   = i - IW'(1);
                        cnt_nxt = '0;
                        dac_nxt = res_upd | (WIDTH'(1) << (i - IW'(1)));
                    end else begin
                        data_nxt  = res_upd;
                        dac_nxt   = res_upd;
                        valid_nxt = 1'b1;
                        if (cont) begin
                            load = 1'b1;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Start actions override the final-code load on a continuous restart
        if (load) begin
            result_nxt = '0;
            i_nxt      = I_MSB;
            cnt_nxt    = '0;
            dac_nxt    = MSB_CODE;
            busy_nxt   = 1'b1;
            state_nxt  = CONV;
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: an ideal comparator against a random
// analog level, with expected conversions queued by stimulus and checked by a monitor.
module tb_sar_adc_ctrl;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;
    localparam int STEP   = SETTLE + 2;
    localparam int CONV   = WIDTH * STEP;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cont;
    logic             cmp;
    logic [WIDTH-1:0] dac_out;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             busy;

    int unsigned vin;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int vin;
        int start;
        bit last;
    } exp_t;

    exp_t q[$];

    sar_adc_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cont    (cont),
        .cmp     (cmp),
        .dac_out (dac_out),
        .data    (data),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal comparator: Vin >= Vdac, equality keeps the bit
    assign cmp = (vin >= 32'(dac_out));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input int act, input int exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Trial code for step k: bits above the trial bit are the answer so far
    function automatic int trial(input int v, input int k);
        int sh;
        sh = WIDTH - k;
        return ((v >> sh) << sh) | (1 << (WIDTH - 1 - k));
    endfunction

    // Monitor: pops the scoreboard on valid and tracks trial codes in flight
    initial begin
        exp_t e;
        int   prev_data;
        prev_data = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_data = 0;
            end else begin
                if (valid) begin
                    if (q.size() == 0) begin
                        fail_event("unexpected_valid", 32'(data), -1);
                    end else begin
                        e = q.pop_front();
                        check("data", 32'(data), e.vin);
                        check("valid_time", cyc, e.start + CONV);
                        check("busy_at_valid", 32'(busy), e.last ? 0 : 1);
                        if (e.last) check("final_dac", 32'(dac_out), e.vin);
                    end
                end else begin
                    check("data_hold", 32'(data), prev_data);
                end
                prev_data = 32'(data);
                if (q.size() != 0) begin
                    e = q[0];
                    if (cyc > e.start + CONV) begin
                        fail_event("missing_valid", cyc, e.start + CONV);
                        void'(q.pop_front());
                    end else if (cyc >= e.start && cyc < e.start + CONV) begin
                        check("dac_trial", 32'(dac_out), trial(e.vin, (cyc - e.start) / STEP));
                        check("busy", 32'(busy), 1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 3 * CONV) begin
            tick();
            n++;
        end
        if (n >= 3 * CONV) begin
            fail_event("idle_timeout", n, 3 * CONV);
            q.delete();
        end
        tick();
    endtask

    // One conversion; optional extra start pulse 'extra' cycles in, which must be ignored
    task automatic single(input int v, input int extra);
        int s;
        vin = 32'(v);
        s = cyc + 1;
        q.push_back('{v, s, 1'b1});
        pulse_start();
        if (extra > 0) begin
            while (cyc < s + extra - 1) tick();
            pulse_start();
        end
        wait_idle();
    endtask

    // Continuous chain; cont dropped during the last conversion
    task automatic chain(input int vs[$]);
        int s;
        int n;
        n = vs.size();
        s = cyc + 1;
        for (int k = 0; k < n; k++) q.push_back('{vs[k], s + CONV * k, k == n - 1});
        vin = 32'(vs[0]);
        cont = 1'b1;
        pulse_start();
        for (int k = 1; k < n; k++) begin
            while (cyc < s + CONV * k) tick();
            vin = 32'(vs[k]);
            if (k == n - 1) cont = 1'b0;
        end
        wait_idle();
    endtask

    // start held through the end of a conversion starts exactly one more
    task automatic held_start(input int v);
        int s;
        vin = 32'(v);
        s = cyc + 1;
        q.push_back('{v, s, 1'b1});
        q.push_back('{v, s + CONV + 1, 1'b1});
        start = 1'b1;
        tick();
        while (cyc < s + CONV + 1) tick();
        start = 1'b0;
        wait_idle();
    endtask

    task automatic reset_mid(input int v);
        int s;
        vin = 32'(v);
        s = cyc + 1;
        q.push_back('{v, s, 1'b1});
        pulse_start();
        while (cyc < s + 7) tick();
        rst = 1'b0;
        #1;
        check("rst_dac", 32'(dac_out), 0);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        q.delete();
        tick();
        tick();
        rst = 1'b1;
        repeat (CONV + 4) tick();
    endtask

    initial begin
        int vs[$];
        rst   = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        vin   = 0;
        #3;
        check("reset_dac", 32'(dac_out), 0);
        check("reset_data", 32'(data), 0);
        check("reset_valid", 32'(valid), 0);
        check("reset_busy", 32'(busy), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        single(11, 0);
        single(0, 0);
        single(15, 0);
        single(6, 0);
        single(9, 5);
        vs = {9, 3};
        chain(vs);
        held_start(13);

        cont = 1'b1;
        repeat (10) begin
            tick();
            check("cont_idle_busy", 32'(busy), 0);
        end
        cont = 1'b0;

        reset_mid(12);
        single(5, 0);

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                vs.delete();
                for (int k = 0; k < int'($urandom_range(2, 3)); k++)
                    vs.push_back(int'($urandom_range(0, 15)));
                chain(vs);
            end else begin
                single(int'($urandom_range(0, 15)),
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 15)) : 0);
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        check("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
